// File: rtl/dm_responder.sv
// Responder end of the CPU data-memory port: a single-outstanding load/store
// engine with a programmable number of wait states before each access.
module dm_responder #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          exec;
    logic          addr_err;
    logic [AW-1:0] idx;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign accept     = req_valid && req_ready;
    assign exec       = (state == S_EXEC);

    // Misaligned or beyond the stored range; high addresses are rejected, never aliased.
    assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != 32'd0);
    assign idx      = addr_q[AW+1:2];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            write_q    <= 1'b0;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        be_q    <= req_be;
                        wdata_q <= req_wdata;
                        if (WAIT == 0) begin
                            state <= S_EXEC;
                        end else begin
                            state <= S_BUSY;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state      <= S_RESP;
                    resp_err   <= addr_err;
                    resp_rdata <= (!write_q && !addr_err) ? mem[idx] : 32'd0;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the storage is cleared by reset, so it is built from resettable
    // flops rather than a RAM macro; an aborted access never reaches EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (exec && write_q && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a WAIT=2 instance for functional checks and
// a WAIT=0 instance for the minimum-latency throughput pattern.
module tb_dm_responder;

    logic clk;
    logic reset;

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_be;
    logic        a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_be;
    logic        b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_resp_rdata;

    int n_pass;
    int n_fail;
    int n_total;

    dm_responder #(.DEPTH(1024), .AW(10), .WAIT(2)) u_a (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_write  (a_req_write),
        .req_addr   (a_req_addr),
        .req_be     (a_req_be),
        .req_wdata  (a_req_wdata),
        .resp_valid (a_resp_valid),
        .resp_ready (a_resp_ready),
        .resp_rdata (a_resp_rdata),
        .resp_err   (a_resp_err)
    );

    dm_responder #(.DEPTH(1024), .AW(10), .WAIT(0)) u_b (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_write  (b_req_write),
        .req_addr   (b_req_addr),
        .req_be     (b_req_be),
        .req_wdata  (b_req_wdata),
        .resp_valid (b_resp_valid),
        .resp_ready (b_resp_ready),
        .resp_rdata (b_resp_rdata),
        .resp_err   (b_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance A starting at a negedge; lat is the number
    // of cycles from the handshake cycle to the first cycle with resp_valid=1.
    task automatic a_access(input logic w, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic finish,
                            output logic [31:0] rdata, output logic err, output int lat);
        a_req_valid = 1'b1;
        a_req_write = w;
        a_req_addr  = addr;
        a_req_be    = be;
        a_req_wdata = wdata;
        @(negedge clk);
        a_req_valid = 1'b0;
        a_req_write = 1'b0;
        a_req_addr  = 32'hFFFF_FFFF;
        a_req_be    = 4'h0;
        a_req_wdata = 32'h5555_5555;
        lat = 1;
        while (!a_resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = a_resp_rdata;
        err   = a_resp_err;
        if (finish) begin
            a_resp_ready = 1'b1;
            @(negedge clk);
            a_resp_ready = 1'b0;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        n_pass = 0;
        n_fail = 0;
        n_total = 0;
        reset = 1'b0;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'd0; a_req_be = 4'h0;
        a_req_wdata = 32'd0; a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'd0; b_req_be = 4'h0;
        b_req_wdata = 32'd0; b_resp_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        chk("rst_rdata", a_resp_rdata, 32'd0);
        chk("rst_err", 32'(a_resp_err), 32'd0);
        chk("rst_b_req_ready", 32'(b_req_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Store then load, WAIT=2 latency
        a_access(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, rd, er, lat);
        chk("st10_lat", 32'(lat), 32'd4);
        chk("st10_err", 32'(er), 32'd0);
        chk("st10_rdata", rd, 32'd0);
        chk("st10_ready_after", 32'(a_req_ready), 32'd1);
        a_access(1'b0, 32'h0000_0010, 4'h0, 32'd0, 1'b1, rd, er, lat);
        chk("ld10_lat", 32'(lat), 32'd4);
        chk("ld10_rdata", rd, 32'hDEAD_BEEF);
        chk("ld10_err", 32'(er), 32'd0);

        // Byte-enable merge
        a_access(1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 1'b1, rd, er, lat);
        a_access(1'b1, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 1'b1, rd, er, lat);
        a_access(1'b0, 32'h0000_0020, 4'hF, 32'd0, 1'b1, rd, er, lat);
        chk("merge_rdata", rd, 32'h11BB_33DD);

        // Back-pressure with ignored request pulses
        a_access(1'b0, 32'h0000_0020, 4'hF, 32'd0, 1'b0, rd, er, lat);
        chk("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            a_req_valid = i[0];
            a_req_write = 1'b1;
            a_req_addr  = 32'h0000_0020;
            a_req_be    = 4'hF;
            a_req_wdata = 32'h0BAD_0BAD;
            @(negedge clk);
            chk("bp_resp_valid", 32'(a_resp_valid), 32'd1);
            chk("bp_rdata", a_resp_rdata, 32'h11BB_33DD);
            chk("bp_req_ready", 32'(a_req_ready), 32'd0);
        end
        a_req_valid = 1'b0;
        a_req_write = 1'b0;
        a_resp_ready = 1'b1;
        @(negedge clk);
        a_resp_ready = 1'b0;
        chk("bp_release_ready", 32'(a_req_ready), 32'd1);
        chk("bp_release_valid", 32'(a_resp_valid), 32'd0);
        a_access(1'b0, 32'h0000_0020, 4'hF, 32'd0, 1'b1, rd, er, lat);
        chk("bp_no_write", rd, 32'h11BB_33DD);

        // Error cases
        a_access(1'b0, 32'h0000_0006, 4'hF, 32'd0, 1'b1, rd, er, lat);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_rdata", rd, 32'd0);
        chk("mis_lat", 32'(lat), 32'd4);
        a_access(1'b1, 32'h0000_1000, 4'hF, 32'hCAFE_F00D, 1'b1, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        a_access(1'b0, 32'h0000_0000, 4'hF, 32'd0, 1'b1, rd, er, lat);
        chk("ld0_rdata", rd, 32'd0);
        chk("ld0_err", 32'(er), 32'd0);

        // be=0 store leaves memory unchanged
        a_access(1'b1, 32'h0000_0010, 4'h0, 32'h1234_5678, 1'b1, rd, er, lat);
        chk("be0_err", 32'(er), 32'd0);
        a_access(1'b0, 32'h0000_0010, 4'hF, 32'd0, 1'b1, rd, er, lat);
        chk("be0_rdata", rd, 32'hDEAD_BEEF);

        // WAIT=0 instance: store, then back-to-back loads with resp_ready tied high
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h0000_0040;
        b_req_be = 4'hF; b_req_wdata = 32'h1234_5678;
        @(negedge clk);
        b_req_valid = 1'b0; b_req_write = 1'b0;
        chk("w0_st_exec_valid", 32'(b_resp_valid), 32'd0);
        @(negedge clk);
        chk("w0_st_resp_valid", 32'(b_resp_valid), 32'd1);
        @(negedge clk);
        chk("w0_st_ready", 32'(b_req_ready), 32'd1);
        b_req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("w0_req_ready", 32'(b_req_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
            chk("w0_resp_valid", 32'(b_resp_valid), (i % 3 == 2) ? 32'd1 : 32'd0);
            if (i % 3 == 2) begin
                chk("w0_rdata", b_resp_rdata, 32'h1234_5678);
            end
            @(negedge clk);
        end
        b_req_valid = 1'b0;

        // Reset while a store to 0x30 is in BUSY
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h0000_0030;
        a_req_be = 4'hF; a_req_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        a_req_valid = 1'b0; a_req_write = 1'b0;
        chk("mid_busy", 32'(a_req_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(a_req_ready), 32'd1);
        chk("mid_rst_valid", 32'(a_resp_valid), 32'd0);
        chk("mid_rst_rdata", a_resp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        a_access(1'b0, 32'h0000_0030, 4'hF, 32'd0, 1'b1, rd, er, lat);
        chk("mid_ld30", rd, 32'd0);
        a_access(1'b0, 32'h0000_0010, 4'hF, 32'd0, 1'b1, rd, er, lat);
        chk("mid_ld10_cleared", rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
